// File: rtl/invader_pkg.sv
// Shared types and width helpers for the invader formation controller,
// its renderer and the collision logic.
package invader_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_MOVE,
    ST_DONE
  } fsm_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/invader_formation_ctrl_if.sv
// Bundle between game FSM, collision logic, sprite renderer and the
// formation controller; the controller sits on the slave modport.
interface invader_formation_ctrl_if #(
  parameter int N       = 40,
  parameter int COORD_W = invader_pkg::COORD_W
);
  localparam int IDX_W = invader_pkg::idx_width(N);
  localparam int CNT_W = invader_pkg::cnt_width(N);

  logic               start;
  logic               enable;
  logic               tick;
  logic               hit_valid;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit_ack;
  logic [N-1:0]       alive;
  logic [CNT_W-1:0]   alive_count;
  logic [COORD_W-1:0] base_x;
  logic [COORD_W-1:0] base_y;
  logic               dir;
  logic               step_pulse;
  logic               landed;
  logic               all_dead;

  modport master (
    output start, enable, tick, hit_valid, hit_idx,
    input  hit_ack, alive, alive_count, base_x, base_y, dir, step_pulse, landed, all_dead
  );

  modport slave (
    input  start, enable, tick, hit_valid, hit_idx,
    output hit_ack, alive, alive_count, base_x, base_y, dir, step_pulse, landed, all_dead
  );

endinterface

// File: rtl/formation_edge_scan.sv
// Column iterator over a frozen alive snapshot: one column per cycle, reports
// the leftmost/rightmost occupied columns and the lowest occupied row.
module formation_edge_scan
  import invader_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 10,
  localparam int N     = ROWS * COLS,
  localparam int COL_W = idx_width(COLS),
  localparam int ROW_W = idx_width(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [N-1:0]     snapshot,
  output logic [COL_W-1:0] min_col,
  output logic [COL_W-1:0] max_col,
  output logic [ROW_W-1:0] max_row,
  output logic             done
);

  logic [N-1:0]     snap_q;
  logic [COL_W-1:0] col_q;
  logic             busy_q;
  logic             found_q;
  logic [ROWS-1:0]  col_bits;
  logic             col_any;
  logic [ROW_W-1:0] col_row;

  // Static mux of the current column keeps every bit select in range.
  always_comb begin
    col_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (col_q == COL_W'(c)) col_bits[r] = snap_q[r*COLS + c];
      end
    end
  end

  always_comb begin
    col_any = |col_bits;
    col_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (col_bits[r]) col_row = ROW_W'(r);
    end
  end

  assign done = busy_q && (col_q == COL_W'(COLS - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      snap_q  <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      min_col <= '0;
      max_col <= '0;
      max_row <= '0;
    end else if (load) begin
      snap_q  <= snapshot;
      col_q   <= '0;
      busy_q  <= 1'b1;
      found_q <= 1'b0;
      min_col <= '0;
      max_col <= '0;
      max_row <= '0;
    end else if (busy_q) begin
      if (col_any) begin
        if (!found_q) min_col <= col_q;
        found_q <= 1'b1;
        max_col <= col_q;
        if (col_row > max_row) max_row <= col_row;
      end
      if (done) busy_q <= 1'b0;
      else      col_q  <= col_q + 1'b1;
    end
  end

endmodule

// File: rtl/invader_formation_ctrl.sv
// Enemy formation controller: alive bitmap, march timing that speeds up as
// enemies die, edge-driven move/drop, kill handshake and landed/all-dead flags.
module invader_formation_ctrl #(
  parameter int ROWS        = 4,
  parameter int COLS        = 10,
  parameter int COORD_W     = invader_pkg::COORD_W,
  parameter int DIST_X      = 30,
  parameter int DIST_Y      = 30,
  parameter int ROW_STAGGER = 10,
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 20,
  parameter int X0          = 150,
  parameter int Y0          = 40,
  parameter int X_MIN       = 150,
  parameter int X_MAX       = 760,
  parameter int DX          = 1,
  parameter int DY          = 50,
  parameter int Y_LAND      = 440,
  parameter int MIN_PERIOD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  invader_formation_ctrl_if.slave bus
);
  import invader_pkg::*;

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = idx_width(N);
  localparam int CNT_W = cnt_width(N);
  localparam int TC_W  = cnt_width(MIN_PERIOD + N);
  localparam int COL_W = idx_width(COLS);
  localparam int ROW_W = idx_width(ROWS);
  localparam int W1    = COORD_W + 1;

  fsm_state_t         state_q, state_d;
  logic [N-1:0]       alive_q, alive_d;
  logic [COORD_W-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic               dir_q, dir_d;
  logic [3:0]         drops_q, drops_d;
  logic [TC_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic               hit_ack_q, hit_ack_d;
  logic               landed_q, landed_d;
  logic               all_dead_q, all_dead_d;

  logic [CNT_W-1:0]   alive_count;
  logic [N-1:0]       hit_mask;
  logic [N-1:0]       alive_after;
  logic               active;
  logic               hit_ok;
  logic [TC_W-1:0]    period_m1;
  logic               scan_load;
  logic               scan_done;
  logic [COL_W-1:0]   min_col, max_col;
  logic [ROW_W-1:0]   max_row;
  logic [W1-1:0]      dx, right_edge, left_edge, bottom_after_drop;
  logic               drop;

  always_comb begin
    alive_count = '0;
    for (int i = 0; i < N; i++) alive_count = alive_count + CNT_W'(alive_q[i]);
  end

  // One-hot decode of the hit index; an out-of-range index decodes to nothing.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < N; i++) hit_mask[i] = bus.hit_valid && (bus.hit_idx == IDX_W'(i));
  end

  assign active      = (state_q == ST_WAIT) || (state_q == ST_SCAN) || (state_q == ST_MOVE);
  assign alive_after = alive_q & ~hit_mask;
  assign hit_ok      = active && |(hit_mask & alive_q);
  assign period_m1   = TC_W'(MIN_PERIOD) + TC_W'(alive_count) - TC_W'(1);
  assign scan_load   = (state_q == ST_WAIT) && (state_d == ST_SCAN);

  formation_edge_scan #(.ROWS(ROWS), .COLS(COLS)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.start),
    .load     (scan_load),
    .snapshot (alive_q),
    .min_col  (min_col),
    .max_col  (max_col),
    .max_row  (max_row),
    .done     (scan_done)
  );

  // Edge sums carry one spare bit so a formation near the top of the range
  // cannot wrap past a bound.
  always_comb begin
    dx                = W1'(DX) + W1'(drops_q);
    right_edge        = W1'(base_x_q) + W1'(max_col) * W1'(DIST_X) + W1'(ROW_STAGGER) + W1'(SPRITE_W);
    left_edge         = W1'(base_x_q) + W1'(min_col) * W1'(DIST_X);
    bottom_after_drop = W1'(base_y_q) + W1'(DY) + W1'(max_row) * W1'(DIST_Y) + W1'(SPRITE_H);
    drop              = dir_q ? (left_edge < W1'(X_MIN) + dx) : (right_edge + dx > W1'(X_MAX));
  end

  always_comb begin
    state_d    = state_q;
    alive_d    = alive_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    dir_d      = dir_q;
    drops_d    = drops_q;
    tick_cnt_d = tick_cnt_q;
    hit_ack_d  = 1'b0;
    landed_d   = landed_q;
    all_dead_d = all_dead_q;
    if (bus.start) begin
      state_d    = ST_WAIT;
      alive_d    = '1;
      base_x_d   = COORD_W'(X0);
      base_y_d   = COORD_W'(Y0);
      dir_d      = 1'b0;
      drops_d    = '0;
      tick_cnt_d = '0;
      landed_d   = 1'b0;
      all_dead_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (bus.enable && bus.tick) begin
            if (tick_cnt_q == period_m1) begin
              tick_cnt_d = '0;
              state_d    = ST_SCAN;
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
          end
        end
        ST_SCAN: if (scan_done) state_d = ST_MOVE;
        ST_MOVE: begin
          state_d = ST_WAIT;
          if (drop) begin
            base_y_d = base_y_q + COORD_W'(DY);
            dir_d    = ~dir_q;
            if (drops_q != 4'hF) drops_d = drops_q + 4'd1;
            if (bottom_after_drop >= W1'(Y_LAND)) begin
              landed_d = 1'b1;
              state_d  = ST_DONE;
            end
          end else if (dir_q) begin
            base_x_d = base_x_q - dx[COORD_W-1:0];
          end else begin
            base_x_d = base_x_q + dx[COORD_W-1:0];
          end
        end
        default: ;
      endcase
      // The last kill wins over any march decision taken this cycle.
      if (hit_ok) begin
        alive_d   = alive_after;
        hit_ack_d = 1'b1;
        if (alive_after == '0) begin
          all_dead_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alive_q    <= '1;
      base_x_q   <= COORD_W'(X0);
      base_y_q   <= COORD_W'(Y0);
      dir_q      <= 1'b0;
      drops_q    <= '0;
      tick_cnt_q <= '0;
      hit_ack_q  <= 1'b0;
      landed_q   <= 1'b0;
      all_dead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alive_q    <= alive_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      dir_q      <= dir_d;
      drops_q    <= drops_d;
      tick_cnt_q <= tick_cnt_d;
      hit_ack_q  <= hit_ack_d;
      landed_q   <= landed_d;
      all_dead_q <= all_dead_d;
    end
  end

  assign bus.hit_ack     = hit_ack_q;
  assign bus.alive       = alive_q;
  assign bus.alive_count = alive_count;
  assign bus.base_x      = base_x_q;
  assign bus.base_y      = base_y_q;
  assign bus.dir         = dir_q;
  assign bus.step_pulse  = (state_q == ST_MOVE);
  assign bus.landed      = landed_q;
  assign bus.all_dead    = all_dead_q;

endmodule
